// File: rtl/twiddle_sched.sv
// ============================================================================
//  Module      : twiddle_sched
//  Description : Sequences one radix-2 stage of an 8-point FFT through a
//                single shared twiddle_mult instance. Each butterfly reads
//                its lower-leg sample, loads the twiddle constants from an
//                internal table, waits for the product and writes it back
//                in place.
//                Optional macro TWIDDLE_SCHED_TIMEOUT_EN adds a WAIT-state
//                watchdog that aborts the stage and raises a sticky o_error.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module twiddle_sched #(
    parameter int N_POINTS     = 8,
    parameter int LOG2N        = 3,
    parameter int MULT_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_stage,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [2:0]  o_rd_addr,
    input  logic [15:0] i_rd_data,
    output logic        o_wr_en,
    output logic [2:0]  o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic        o_mult_start,
    output logic [7:0]  o_x,
    output logic [7:0]  o_y,
    output logic [7:0]  o_c,
    output logic [8:0]  o_c_plus_s,
    output logic [8:0]  o_c_minus_s,
    input  logic        i_mult_dv,
    input  logic [7:0]  i_re,
    input  logic [7:0]  i_im
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_stage;
    logic [1:0]  r_j;
    logic [2:0]  w_addr;
    logic [1:0]  w_k;
    logic [7:0]  w_c;
    logic [7:0]  w_s;
    logic [8:0]  w_cps;
    logic [8:0]  w_cms;
    logic        w_valid_stage;
    logic        w_last;
    logic        w_timeout;
    logic        r_mult_start;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_c;
    logic [8:0]  r_cps;
    logic [8:0]  r_cms;
    logic [15:0] r_wr_data;

    assign w_valid_stage = ({1'b0, i_stage} < 3'(LOG2N));
    assign w_last        = (r_j == 2'(N_POINTS / 2 - 1));

    // Butterfly address and twiddle index, specialised for 8 points:
    // addr = (j>>s)*2*span + span + (j & (span-1)), k = (j & (span-1)) * 4/span
    always_comb begin
        w_addr = 3'd0;
        w_k    = 2'd0;
        case (r_stage)
            2'd0: begin
                w_addr = {r_j, 1'b1};
                w_k    = 2'd0;
            end
            2'd1: begin
                w_addr = {r_j[1], 1'b1, r_j[0]};
                w_k    = {r_j[0], 1'b0};
            end
            default: begin
                w_addr = {1'b1, r_j};
                w_k    = r_j;
            end
        endcase
    end

    // Twiddle table W^k = c + j*s with s = -sin, Q1.7; sums are exact 9-bit
    always_comb begin
        w_c = 8'sd127;
        w_s = 8'sd0;
        case (w_k)
            2'd0: begin w_c = 8'd127;  w_s = 8'd0;   end
            2'd1: begin w_c = 8'd90;   w_s = 8'hA6;  end
            2'd2: begin w_c = 8'd0;    w_s = 8'h81;  end
            default: begin w_c = 8'hA6; w_s = 8'hA6; end
        endcase
        w_cps = {w_c[7], w_c} + {w_s[7], w_s};
        w_cms = {w_c[7], w_c} - {w_s[7], w_s};
    end

`ifdef TWIDDLE_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(MULT_TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             r_error;

    assign w_timeout = (r_state == S_WAIT) && !i_mult_dv &&
                       (r_tmo == TMO_W'(MULT_TIMEOUT - 1));

    // Watchdog: counts WAIT cycles, sticky error cleared by the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo   <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_tmo <= '0;
            end else if (r_state == S_WAIT && !i_mult_dv) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (r_state == S_IDLE && i_start) begin
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_error = r_error;
`else
    assign w_timeout = 1'b0;
    assign o_error   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; starts are only accepted from IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = w_valid_stage ? S_READ : S_DONE;
                end
            end
            S_READ:  w_next = S_LOAD;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT: begin
                if (i_mult_dv) begin
                    w_next = S_WRITE;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_WRITE: w_next = w_last ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: stage/butterfly counters, operand registers, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage      <= 2'd0;
            r_j          <= 2'd0;
            r_mult_start <= 1'b0;
            r_x          <= 8'd0;
            r_y          <= 8'd0;
            r_c          <= 8'd0;
            r_cps        <= 9'd0;
            r_cms        <= 9'd0;
            r_wr_data    <= 16'd0;
        end else begin
            r_mult_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && w_valid_stage) begin
                        r_stage <= i_stage;
                        r_j     <= 2'd0;
                    end
                end
                S_LOAD: begin
                    r_x          <= i_rd_data[15:8];
                    r_y          <= i_rd_data[7:0];
                    r_c          <= w_c;
                    r_cps        <= w_cps;
                    r_cms        <= w_cms;
                    r_mult_start <= 1'b1;
                end
                S_WAIT: begin
                    if (i_mult_dv) begin
                        r_wr_data <= {i_re, i_im};
                    end
                end
                S_WRITE: begin
                    if (!w_last) begin
                        r_j <= r_j + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (r_state == S_READ) || (r_state == S_LOAD) ||
                          (r_state == S_WAIT) || (r_state == S_WRITE);
    assign o_done       = (r_state == S_DONE);
    assign o_rd_addr    = (r_state == S_READ)  ? w_addr : 3'd0;
    assign o_wr_en      = (r_state == S_WRITE);
    assign o_wr_addr    = (r_state == S_WRITE) ? w_addr : 3'd0;
    assign o_wr_data    = r_wr_data;
    assign o_mult_start = r_mult_start;
    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_c          = r_c;
    assign o_c_plus_s   = r_cps;
    assign o_c_minus_s  = r_cms;

endmodule

`default_nettype wire
